// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the key_debounce block.
// Optional auto-repeat is enabled with the KEY_DEBOUNCE_AUTOREPEAT_EN macro.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_UP   = 2'd0,
        WAIT_DOWN   = 2'd1,
        STABLE_DOWN = 2'd2,
        WAIT_UP     = 2'd3
    } key_state_e;

    // 10 ms at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Bits needed to hold 0..max_count inclusive; never below one bit.
    function automatic int cnt_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end else begin
            return $clog2(max_count + 1);
        end
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One push-button channel: 2-flop synchronizer, debounce FSM with stability
// counter and registered level/press/release outputs. Auto-repeat under KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw_n,
    output logic key_n,
    output logic press,
    // "release" is a reserved word in SystemVerilog
    output logic release_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_DELAY);
    // Reload value re-arms the next pulse REPEAT_PERIOD cycles later; assumes REPEAT_PERIOD <= REPEAT_DELAY.
    localparam logic [RW-1:0] RPT_FIRST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [RW-1:0] RPT_ONE    = RW'(1);

    logic [RW-1:0] rpt_cnt_r;
`endif

    logic [1:0]    sync_r;
    logic          sample_s;
    key_state_e    state_r;
    logic [CW-1:0] cnt_r;
    logic          key_n_r;
    logic          press_r;
    logic          release_r;

    assign sample_s = sync_r[1];

    // Two-stage synchronizer for the asynchronous raw button level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], key_raw_n};
        end
    end

    // Debounce FSM: a level change is accepted only after the sample has held
    // the new value while the counter walks from 1 up to DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= STABLE_UP;
            cnt_r     <= {CW{1'b0}};
            key_n_r   <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rpt_cnt_r <= {RW{1'b0}};
`endif
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rpt_cnt_r <= {RW{1'b0}};
`endif
            case (state_r)
                STABLE_UP: begin
                    if (!sample_s) begin
                        state_r <= WAIT_DOWN;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                WAIT_DOWN: begin
                    if (sample_s) begin
                        state_r <= STABLE_UP;
                        cnt_r   <= {CW{1'b0}};
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= STABLE_DOWN;
                        cnt_r   <= {CW{1'b0}};
                        key_n_r <= 1'b0;
                        press_r <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                STABLE_DOWN: begin
                    if (sample_s) begin
                        state_r <= WAIT_UP;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= {CW{1'b0}};
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                        if (rpt_cnt_r == RPT_FIRST) begin
                            press_r   <= 1'b1;
                            rpt_cnt_r <= RPT_RELOAD;
                        end else begin
                            rpt_cnt_r <= rpt_cnt_r + RPT_ONE;
                        end
`endif
                    end
                end
                WAIT_UP: begin
                    if (!sample_s) begin
                        state_r   <= STABLE_DOWN;
                        cnt_r     <= {CW{1'b0}};
                    end else if (cnt_r == CNT_MAX) begin
                        state_r   <= STABLE_UP;
                        cnt_r     <= {CW{1'b0}};
                        key_n_r   <= 1'b1;
                        release_r <= 1'b1;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= STABLE_UP;
                    cnt_r   <= {CW{1'b0}};
                    key_n_r <= 1'b1;
                end
            endcase
        end
    end

    assign key_n         = key_n_r;
    assign press         = press_r;
    assign release_pulse = release_r;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button debouncer; keys_n is a drop-in for a PIO in_port.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add held-key auto-repeat on press.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] keys_raw_n,
    output logic [NKEYS-1:0] keys_n,
    output logic [NKEYS-1:0] press,
    output logic [NKEYS-1:0] release_pulse
);

    for (genvar g = 0; g < NKEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_raw_n     (keys_raw_n[g]),
            .key_n         (keys_n[g]),
            .press         (press[g]),
            .release_pulse (release_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random button
// activity, compared every cycle against a run-length reference model.
module tb_key_debounce;

    localparam int NK = 4;
    localparam int DC = 4;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int RD = 10;
    localparam int RP = 3;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NK-1:0] keys_raw_n = 4'hF;
    logic [NK-1:0] keys_n;
    logic [NK-1:0] press;
    logic [NK-1:0] release_pulse;

    int checks = 0;
    int passed = 0;

    // Reference model: raw level delayed two edges, then a run of DC+1
    // consecutive differing samples flips the accepted level.
    logic [NK-1:0] m_d1, m_d2, m_level, m_press, m_rel;
    int m_run [NK];
    int m_age [NK];

    key_debounce #(
        .NKEYS           (NK),
        .DEBOUNCE_CYCLES (DC)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .keys_raw_n    (keys_raw_n),
        .keys_n        (keys_n),
        .press         (press),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %h expected %h (check %0d)", tag, obs, exp_v, checks);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs == exp_v) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        m_d1    = 4'hF;
        m_d2    = 4'hF;
        m_level = 4'hF;
        m_press = 4'h0;
        m_rel   = 4'h0;
        for (int ch = 0; ch < NK; ch++) begin
            m_run[ch] = 0;
            m_age[ch] = 0;
        end
    endtask

    // One clock edge: advance the model, then compare all outputs 1 ns later.
    task automatic step();
        logic [NK-1:0] s;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        logic [NK-1:0] rdy;
`endif
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            s       = m_d2;
            m_d2    = m_d1;
            m_d1    = keys_raw_n;
            m_press = 4'h0;
            m_rel   = 4'h0;
            for (int ch = 0; ch < NK; ch++) begin
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                rdy[ch] = (m_level[ch] == 1'b0) && (s[ch] == 1'b0) && (m_run[ch] == 0);
`endif
                if (s[ch] != m_level[ch]) m_run[ch]++;
                else m_run[ch] = 0;
                if (m_run[ch] == DC + 1) begin
                    m_level[ch] = s[ch];
                    m_run[ch]   = 0;
                    if (s[ch] == 1'b0) m_press[ch] = 1'b1;
                    else m_rel[ch] = 1'b1;
                end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                if (rdy[ch]) begin
                    m_age[ch]++;
                    if (m_age[ch] >= RD && ((m_age[ch] - RD) % RP) == 0) m_press[ch] = 1'b1;
                end else begin
                    m_age[ch] = 0;
                end
`endif
            end
        end
        #1;
        chk("keys_n", keys_n, m_level);
        chk("press", press, m_press);
        chk("release", release_pulse, m_rel);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int p_edge;
        int p_cnt;
        model_reset();

        // Asynchronous reset, then idle keys for 20 cycles
        #2 reset_n = 1'b0;
        #1;
        chk("reset_keys_n", keys_n, 4'hF);
        chk("reset_press", press, 4'h0);
        chk("reset_release", release_pulse, 4'h0);
        run(3);
        reset_n = 1'b1;
        run(20);

        // Key 0 press: accepted on edge 6 after the first sampling edge
        keys_raw_n[0] = 1'b0;
        p_edge = -1;
        p_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (press[0] === 1'b1) begin
                p_cnt++;
                if (p_edge < 0) p_edge = i;
            end
        end
        chk_int("press0_edge", p_edge, 6);
        chk_int("press0_count", p_cnt, 1);
        keys_raw_n[0] = 1'b1;
        run(10);

        // Key 1 glitches on press side, then on release side
        keys_raw_n[1] = 1'b0;
        run(3);
        keys_raw_n[1] = 1'b1;
        run(10);
        keys_raw_n[1] = 1'b0;
        run(10);
        keys_raw_n[1] = 1'b1;
        run(3);
        keys_raw_n[1] = 1'b0;
        run(10);
        keys_raw_n[1] = 1'b1;
        run(10);

        // Keys 2 and 3 fall together; key 3 rises 10 cycles later
        keys_raw_n[3:2] = 2'b00;
        run(10);
        keys_raw_n[3] = 1'b1;
        run(10);
        keys_raw_n[2] = 1'b1;
        run(10);

        // Reset two cycles into WAIT_DOWN with key 0 held through it
        keys_raw_n[0] = 1'b0;
        run(4);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midwait_keys_n", keys_n, 4'hF);
        chk("midwait_press", press, 4'h0);
        run(2);
        reset_n = 1'b1;
        p_edge = -1;
        p_cnt  = 0;
        for (int i = 0; i < 37; i++) begin
            step();
            if (press[0] === 1'b1) begin
                p_cnt++;
                if (p_edge < 0) p_edge = i;
            end
        end
        chk_int("postreset_press_edge", p_edge, 6);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        chk_int("repeat_press_count", p_cnt, 8);
`else
        chk_int("single_press_count", p_cnt, 1);
`endif
        keys_raw_n[0] = 1'b1;
        run(20);

        // Random button activity: mix of glitches and accepted edges
        for (int i = 0; i < 600; i++) begin
            for (int ch = 0; ch < NK; ch++) begin
                if ($urandom_range(0, 7) == 0) keys_raw_n[ch] = ~keys_raw_n[ch];
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NKEYS, default 4: number of push-button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable clk cycles needed to accept a level change (10 ms at 50 MHz); legal range 2..2^24.
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port keys_raw_n, input, NKEYS: raw active-low board buttons, asynchronous to clk.
REQ-006 SHALL have port keys_n, output, NKEYS: debounced active-low level, drop-in for the PIO in_port.
REQ-007 SHALL have port press, output, NKEYS: one-cycle active-high pulse per accepted press (high-to-low on keys_n).
REQ-008 SHALL have port release, output, NKEYS: one-cycle active-high pulse per accepted release (low-to-high on keys_n).

Function
REQ-009 SHALL pass each keys_raw_n bit through a 2-flop synchronizer before any other logic; the second-stage output is the channel sample s.
REQ-010 SHALL run one independent FSM per channel, states STABLE_UP, WAIT_DOWN, STABLE_DOWN, WAIT_UP.
REQ-011 In STABLE_UP with s=0: go to WAIT_DOWN and load counter to 1; with s=1: stay, counter held at 0.
REQ-012 In WAIT_DOWN with s=0: increment counter; when counter reaches DEBOUNCE_CYCLES, go to STABLE_DOWN, clear counter, drive keys_n bit low and press bit high for exactly that one cycle.
REQ-013 In WAIT_DOWN with s=1 (glitch): return to STABLE_UP, clear counter, no pulse, keys_n unchanged.
REQ-014 STABLE_DOWN/WAIT_UP SHALL mirror REQ-011..013 with polarity inverted, producing release instead of press.
REQ-015 Accept latency: keys_n SHALL change on the clk edge DEBOUNCE_CYCLES+2 after the first clk edge that samples the new raw level, given the raw level stays constant.
REQ-016 Counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, saturate-free (never exceeds DEBOUNCE_CYCLES), no wrap-around.
REQ-017 press and release for the same channel SHALL never be high in the same cycle; different channels SHALL be fully independent, simultaneous events allowed.
REQ-018 keys_n, press and release SHALL be registered outputs (no combinational path from keys_raw_n).

Reset
REQ-019 Reset SHALL asynchronously force all FSMs to STABLE_UP, counters to 0, synchronizer flops to 1, keys_n to all-ones, press and release to all-zeros.
REQ-020 A button held during reset release SHALL produce one press pulse DEBOUNCE_CYCLES+2 cycles after the first post-reset edge; reset mid-WAIT SHALL discard the partial count and emit no pulse.

Configuration
REQ-021 Macro KEY_DEBOUNCE_AUTOREPEAT_EN SHALL, when defined, add parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 5000000): while in STABLE_DOWN, press re-pulses first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles, until leaving STABLE_DOWN; the repeat counter clears on every state exit.
REQ-022 Without KEY_DEBOUNCE_AUTOREPEAT_EN, no repeat counter or parameters SHALL exist and press pulses only once per accepted press.

Structure
REQ-023 Package key_debounce_pkg SHALL hold the FSM state enum typedef, default DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD constants.
REQ-024 Per-channel logic (synchronizer, FSM, counters) SHALL be sub-module key_debounce_chan, instantiated NKEYS times via generate.

Verification (DEBOUNCE_CYCLES=4, NKEYS=4; repeat build REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-025 Reset release, all keys_raw_n=1 for 20 cycles -> keys_n=4'hF, press=release=0 throughout.
REQ-026 keys_raw_n[0] to 0 at edge 0, held -> keys_n[0] low and press[0] high on edge 6 only, press[0] low on edge 7.
REQ-027 keys_raw_n[1] low for 3 cycles then high (glitch) -> no press[1], keys_n[1] stays 1; same glitch on release side -> no release.
REQ-028 keys_raw_n[2] and [3] fall same edge, [3] rises 10 cycles later -> press[2],press[3] same cycle; release[3] 6 edges after rise; keys_n[2] stays 0.
REQ-029 reset_n asserted 2 cycles into WAIT_DOWN on key 0, deasserted with key still held -> no pulse during reset, single press[0] 6 edges after first post-reset edge.
REQ-030 AUTOREPEAT_EN build, key 0 held 30 cycles after accept -> extra press[0] pulses at +10, +13, +16, +19, +22, +25, +28 cycles; none after release.
